// File: rtl/axi_outstanding_limiter_if.sv
// AXI4 channel bundle shared by the kernel side and the relay-pipeline side of the limiter.
// The master modport is the initiator's view; slave is the responder's view.
interface axi_outstanding_limiter_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 512,
  parameter int STRB_W = 64
);
  logic              AWVALID;
  logic              AWREADY;
  logic [ADDR_W-1:0] AWADDR;
  logic [1:0]        AWBURST;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [ID_W-1:0]   AWID;
  logic              WVALID;
  logic              WREADY;
  logic [DATA_W-1:0] WDATA;
  logic [STRB_W-1:0] WSTRB;
  logic              WLAST;
  logic              BVALID;
  logic              BREADY;
  logic [1:0]        BRESP;
  logic [ID_W-1:0]   BID;
  logic              ARVALID;
  logic              ARREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic [1:0]        ARBURST;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [ID_W-1:0]   ARID;
  logic              RVALID;
  logic              RREADY;
  logic [DATA_W-1:0] RDATA;
  logic              RLAST;
  logic [ID_W-1:0]   RID;
  logic [1:0]        RRESP;

  modport master (
    output AWVALID, AWADDR, AWBURST, AWLEN, AWSIZE, AWID, input AWREADY,
    output WVALID, WDATA, WSTRB, WLAST, input WREADY,
    input BVALID, BRESP, BID, output BREADY,
    output ARVALID, ARADDR, ARBURST, ARLEN, ARSIZE, ARID, input ARREADY,
    input RVALID, RDATA, RLAST, RID, RRESP, output RREADY
  );

  modport slave (
    input AWVALID, AWADDR, AWBURST, AWLEN, AWSIZE, AWID, output AWREADY,
    input WVALID, WDATA, WSTRB, WLAST, output WREADY,
    output BVALID, BRESP, BID, input BREADY,
    input ARVALID, ARADDR, ARBURST, ARLEN, ARSIZE, ARID, output ARREADY,
    output RVALID, RDATA, RLAST, RID, RRESP, input RREADY
  );
endinterface

// File: rtl/axi_outstanding_limiter.sv
// Caps in-flight AXI read/write bursts and holds W beats back until their AW is accepted.
// All channels pass through combinationally; the only state is the three counters.
module axi_outstanding_limiter #(
  parameter int C_M_AXI_ID_WIDTH    = 8,
  parameter int C_M_AXI_ADDR_WIDTH  = 32,
  parameter int C_M_AXI_DATA_WIDTH  = 512,
  parameter int C_M_AXI_WSTRB_WIDTH = 64,
  parameter int MAX_RD_OUTSTANDING  = 16,
  parameter int MAX_WR_OUTSTANDING  = 16,
  localparam int MAX_CNT   = (MAX_RD_OUTSTANDING > MAX_WR_OUTSTANDING) ?
                             MAX_RD_OUTSTANDING : MAX_WR_OUTSTANDING,
  localparam int CNT_WIDTH = $clog2(MAX_CNT + 1)
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  axi_outstanding_limiter_if.slave  s,
  axi_outstanding_limiter_if.master m,
  output logic [CNT_WIDTH-1:0]     rd_outstanding,
  output logic [CNT_WIDTH-1:0]     wr_outstanding,
  output logic                     err_underflow
);

  localparam logic [CNT_WIDTH-1:0] RD_LIMIT = CNT_WIDTH'(MAX_RD_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] WR_LIMIT = CNT_WIDTH'(MAX_WR_OUTSTANDING);

  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH:0]   aw_pend;
  logic                 rd_ok, wr_ok, w_ok;
  logic                 ar_fire, r_done, aw_fire, b_done, w_last_fire;

  // Counter step that floors at zero; an unmatched completion never wraps the count.
  function automatic logic [CNT_WIDTH-1:0] sat_step(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic inc, input logic dec);
    if (inc && !dec)
      return cnt + CNT_WIDTH'(1);
    else if (dec && !inc)
      return (cnt == '0) ? '0 : cnt - CNT_WIDTH'(1);
    return cnt;
  endfunction

  // Gates use registered counts only, and are forced shut while reset is held.
  assign rd_ok = !ap_rst && (rd_cnt < RD_LIMIT);
  assign wr_ok = !ap_rst && (wr_cnt < WR_LIMIT);
  assign w_ok  = !ap_rst && (aw_pend != '0);

  assign m.ARVALID = s.ARVALID & rd_ok;
  assign s.ARREADY = m.ARREADY & rd_ok;
  assign m.ARADDR  = s.ARADDR;
  assign m.ARBURST = s.ARBURST;
  assign m.ARLEN   = s.ARLEN;
  assign m.ARSIZE  = s.ARSIZE;
  assign m.ARID    = s.ARID;

  assign m.AWVALID = s.AWVALID & wr_ok;
  assign s.AWREADY = m.AWREADY & wr_ok;
  assign m.AWADDR  = s.AWADDR;
  assign m.AWBURST = s.AWBURST;
  assign m.AWLEN   = s.AWLEN;
  assign m.AWSIZE  = s.AWSIZE;
  assign m.AWID    = s.AWID;

  assign m.WVALID  = s.WVALID & w_ok;
  assign s.WREADY  = m.WREADY & w_ok;
  assign m.WDATA   = s.WDATA;
  assign m.WSTRB   = s.WSTRB;
  assign m.WLAST   = s.WLAST;

  assign s.RVALID  = m.RVALID;
  assign m.RREADY  = s.RREADY;
  assign s.RDATA   = m.RDATA;
  assign s.RLAST   = m.RLAST;
  assign s.RID     = m.RID;
  assign s.RRESP   = m.RRESP;

  assign s.BVALID  = m.BVALID;
  assign m.BREADY  = s.BREADY;
  assign s.BRESP   = m.BRESP;
  assign s.BID     = m.BID;

  assign ar_fire     = m.ARVALID & m.ARREADY;
  assign r_done      = m.RVALID & m.RREADY & m.RLAST;
  assign aw_fire     = m.AWVALID & m.AWREADY;
  assign b_done      = m.BVALID & m.BREADY;
  assign w_last_fire = m.WVALID & m.WREADY & m.WLAST;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      aw_pend       <= '0;
      err_underflow <= 1'b0;
    end else begin
      rd_cnt <= sat_step(rd_cnt, ar_fire, r_done);
      wr_cnt <= sat_step(wr_cnt, aw_fire, b_done);
      // W beats are only admitted while aw_pend is nonzero, so this never underflows.
      if (aw_fire && !w_last_fire)
        aw_pend <= aw_pend + (CNT_WIDTH+1)'(1);
      else if (w_last_fire && !aw_fire)
        aw_pend <= aw_pend - (CNT_WIDTH+1)'(1);
      if ((r_done && rd_cnt == '0) || (b_done && wr_cnt == '0))
        err_underflow <= 1'b1;
    end
  end

  assign rd_outstanding = rd_cnt;
  assign wr_outstanding = wr_cnt;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed and randomized bench for axi_outstanding_limiter against a counting model.
`timescale 1ns/1ps
module tb_axi_outstanding_limiter;
  localparam int MAX_RD = 16;
  localparam int MAX_WR = 16;
  localparam int CW     = $clog2(17);

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  logic [CW-1:0] rd_outstanding, wr_outstanding;
  logic err_underflow;

  axi_outstanding_limiter_if #(.ID_W(8), .ADDR_W(32), .DATA_W(64), .STRB_W(8)) s_if ();
  axi_outstanding_limiter_if #(.ID_W(8), .ADDR_W(32), .DATA_W(64), .STRB_W(8)) m_if ();

  axi_outstanding_limiter #(
    .C_M_AXI_ID_WIDTH(8), .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(64),
    .C_M_AXI_WSTRB_WIDTH(8), .MAX_RD_OUTSTANDING(MAX_RD), .MAX_WR_OUTSTANDING(MAX_WR)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .s(s_if.slave), .m(m_if.master),
    .rd_outstanding(rd_outstanding), .wr_outstanding(wr_outstanding),
    .err_underflow(err_underflow)
  );

  always #5 ap_clk = ~ap_clk;

  int pass_cnt = 0;
  int total    = 0;
  int mdl_rd = 0, mdl_wr = 0, mdl_awp = 0;
  bit mdl_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock: check gating/pass-through, predict handshakes, then check counters after the edge.
  task automatic do_cycle();
    bit rd_ok, wr_ok, w_ok, ar_f, r_d, aw_f, b_d, wl_f;
    #1;
    rd_ok = mdl_rd < MAX_RD;
    wr_ok = mdl_wr < MAX_WR;
    w_ok  = mdl_awp > 0;
    chk("m_arvalid", m_if.ARVALID, s_if.ARVALID & rd_ok);
    chk("s_arready", s_if.ARREADY, m_if.ARREADY & rd_ok);
    chk("m_awvalid", m_if.AWVALID, s_if.AWVALID & wr_ok);
    chk("s_awready", s_if.AWREADY, m_if.AWREADY & wr_ok);
    chk("m_wvalid",  m_if.WVALID,  s_if.WVALID & w_ok);
    chk("s_wready",  s_if.WREADY,  m_if.WREADY & w_ok);
    chk("s_rvalid",  s_if.RVALID,  m_if.RVALID);
    chk("m_bready",  m_if.BREADY,  s_if.BREADY);
    chk("m_araddr",  m_if.ARADDR,  s_if.ARADDR);
    chk("m_wdata",   m_if.WDATA,   s_if.WDATA);
    chk("s_rdata",   s_if.RDATA,   m_if.RDATA);
    chk("s_bresp",   s_if.BRESP,   m_if.BRESP);
    ar_f = s_if.ARVALID && m_if.ARREADY && rd_ok;
    aw_f = s_if.AWVALID && m_if.AWREADY && wr_ok;
    wl_f = s_if.WVALID && m_if.WREADY && w_ok && s_if.WLAST;
    r_d  = m_if.RVALID && s_if.RREADY && m_if.RLAST;
    b_d  = m_if.BVALID && s_if.BREADY;
    @(posedge ap_clk);
    #1;
    if ((r_d && mdl_rd == 0) || (b_d && mdl_wr == 0)) mdl_err = 1;
    mdl_rd  = mdl_rd + int'(ar_f) - int'(r_d);
    if (mdl_rd < 0) mdl_rd = 0;
    mdl_wr  = mdl_wr + int'(aw_f) - int'(b_d);
    if (mdl_wr < 0) mdl_wr = 0;
    mdl_awp = mdl_awp + int'(aw_f) - int'(wl_f);
    chk("rd_outstanding", rd_outstanding, mdl_rd);
    chk("wr_outstanding", wr_outstanding, mdl_wr);
    chk("err_underflow",  err_underflow,  mdl_err);
  endtask

  task automatic clear_inputs();
    s_if.AWVALID = 0; s_if.AWADDR = '0; s_if.AWBURST = 2'd1; s_if.AWLEN = '0; s_if.AWSIZE = 3'd3;
    s_if.AWID = '0; s_if.WVALID = 0; s_if.WDATA = '0; s_if.WSTRB = '1; s_if.WLAST = 0;
    s_if.BREADY = 1; s_if.ARVALID = 0; s_if.ARADDR = '0; s_if.ARBURST = 2'd1; s_if.ARLEN = '0;
    s_if.ARSIZE = 3'd3; s_if.ARID = '0; s_if.RREADY = 1;
    m_if.AWREADY = 0; m_if.WREADY = 0; m_if.BVALID = 0; m_if.BRESP = '0; m_if.BID = '0;
    m_if.ARREADY = 0; m_if.RVALID = 0; m_if.RDATA = '0; m_if.RLAST = 0; m_if.RID = '0; m_if.RRESP = '0;
  endtask

  initial begin
    clear_inputs();
    // Reset: valids requested upstream must stay gated low.
    s_if.ARVALID = 1; s_if.AWVALID = 1; s_if.WVALID = 1;
    m_if.ARREADY = 1; m_if.AWREADY = 1; m_if.WREADY = 1;
    repeat (2) @(posedge ap_clk);
    #1;
    chk("rst_rd", rd_outstanding, 0);
    chk("rst_wr", wr_outstanding, 0);
    chk("rst_err", err_underflow, 0);
    chk("rst_m_arvalid", m_if.ARVALID, 0);
    chk("rst_m_awvalid", m_if.AWVALID, 0);
    chk("rst_m_wvalid",  m_if.WVALID, 0);
    clear_inputs();
    ap_rst = 0;

    // 1: sixteen back-to-back ARs, the 17th is held.
    s_if.ARVALID = 1; m_if.ARREADY = 1;
    for (int i = 0; i < 16; i++) begin
      s_if.ARADDR = 32'h1000 + 32'(i * 64);
      do_cycle();
    end
    chk("t1_rd16", rd_outstanding, 16);
    #1;
    chk("t1_s_arready", s_if.ARREADY, 0);
    chk("t1_m_arvalid", m_if.ARVALID, 0);
    do_cycle();

    // 2: a four-beat R burst frees a slot; the held AR fires the cycle after RLAST.
    m_if.RVALID = 1;
    for (int i = 0; i < 4; i++) begin
      m_if.RLAST = (i == 3);
      m_if.RDATA = 64'hA5A5_0000_0000_0000 + 64'(i);
      do_cycle();
    end
    chk("t2_rd15", rd_outstanding, 15);
    m_if.RVALID = 0; m_if.RLAST = 0;
    #1;
    chk("t2_s_arready", s_if.ARREADY, 1);
    do_cycle();
    chk("t2_rd16", rd_outstanding, 16);

    // 3: drain to 5, simultaneous fire+done holds; then at 16 the request is refused.
    s_if.ARVALID = 0; m_if.RVALID = 1; m_if.RLAST = 1;
    repeat (11) do_cycle();
    chk("t3_rd5", rd_outstanding, 5);
    s_if.ARVALID = 1;
    do_cycle();
    chk("t3_rd5_same", rd_outstanding, 5);
    m_if.RVALID = 0;
    repeat (11) do_cycle();
    chk("t3_rd16", rd_outstanding, 16);
    m_if.RVALID = 1;
    #1;
    chk("t3_max_s_arready", s_if.ARREADY, 0);
    do_cycle();
    chk("t3_rd15", rd_outstanding, 15);
    s_if.ARVALID = 0;
    repeat (15) do_cycle();
    m_if.RVALID = 0; m_if.RLAST = 0;
    chk("t3_rd0", rd_outstanding, 0);

    // 4: W waits for AW; LEN=1 admits two beats and a third blocks.
    s_if.WVALID = 1; s_if.WLAST = 0; m_if.WREADY = 1;
    repeat (3) begin
      #1;
      chk("t4_w_early", m_if.WVALID, 0);
      do_cycle();
    end
    s_if.AWVALID = 1; s_if.AWLEN = 8'd1; m_if.AWREADY = 1;
    #1;
    chk("t4_w_same_aw", m_if.WVALID, 0);
    do_cycle();
    s_if.AWVALID = 0;
    #1;
    chk("t4_w_open", m_if.WVALID, 1);
    do_cycle();
    s_if.WLAST = 1;
    do_cycle();
    s_if.WLAST = 0;
    #1;
    chk("t4_w_blocked", m_if.WVALID, 0);
    chk("t4_wready_blocked", s_if.WREADY, 0);
    do_cycle();
    s_if.WVALID = 0;
    chk("t4_wr1", wr_outstanding, 1);

    // 5: B drains to zero, then an unmatched B sets the sticky error.
    m_if.BVALID = 1;
    do_cycle();
    chk("t5_err_clear", err_underflow, 0);
    do_cycle();
    m_if.BVALID = 0;
    chk("t5_err_set", err_underflow, 1);
    chk("t5_wr0", wr_outstanding, 0);
    repeat (3) do_cycle();
    chk("t5_err_sticky", err_underflow, 1);

    // 6: build 7 reads / 4 writes, then assert reset mid-cycle.
    s_if.ARVALID = 1; m_if.ARREADY = 1; s_if.AWVALID = 1; m_if.AWREADY = 1;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) s_if.AWVALID = 0;
      do_cycle();
    end
    chk("t6_rd7", rd_outstanding, 7);
    chk("t6_wr4", wr_outstanding, 4);
    s_if.AWVALID = 1; s_if.WVALID = 1; m_if.WREADY = 1;
    #1;
    ap_rst = 1;
    #1;
    chk("t6_rd0", rd_outstanding, 0);
    chk("t6_wr0", wr_outstanding, 0);
    chk("t6_err0", err_underflow, 0);
    chk("t6_m_arvalid", m_if.ARVALID, 0);
    chk("t6_m_awvalid", m_if.AWVALID, 0);
    chk("t6_m_wvalid",  m_if.WVALID, 0);
    mdl_rd = 0; mdl_wr = 0; mdl_awp = 0; mdl_err = 0;
    clear_inputs();
    repeat (2) @(posedge ap_clk);
    #1;
    ap_rst = 0;

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      s_if.ARVALID = ($urandom_range(0, 3) != 0);
      s_if.ARADDR  = $urandom;
      s_if.ARID    = 8'($urandom);
      m_if.ARREADY = ($urandom_range(0, 3) != 0);
      s_if.AWVALID = ($urandom_range(0, 2) != 0);
      s_if.AWADDR  = $urandom;
      m_if.AWREADY = ($urandom_range(0, 3) != 0);
      s_if.WVALID  = $urandom_range(0, 1);
      s_if.WDATA   = {$urandom, $urandom};
      s_if.WLAST   = ($urandom_range(0, 2) == 0);
      m_if.WREADY  = $urandom_range(0, 1);
      m_if.RVALID  = $urandom_range(0, 1);
      m_if.RLAST   = ($urandom_range(0, 2) == 0);
      m_if.RDATA   = {$urandom, $urandom};
      s_if.RREADY  = ($urandom_range(0, 3) != 0);
      m_if.BVALID  = ($urandom_range(0, 4) == 0);
      m_if.BRESP   = 2'($urandom);
      s_if.BREADY  = $urandom_range(0, 1);
      do_cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
